// File: rtl/neuron_seq_ctrl_if.sv
// Bus bundle for the perceptron sequencer: config write port, input vector
// stream and result stream.
interface neuron_seq_ctrl_if #(
    parameter int N_IN   = 20,
    parameter int W_W    = 8,
    parameter int ACC_W  = 13,
    parameter int ADDR_W = 5
);
    logic                     cfg_we;
    logic [ADDR_W-1:0]        cfg_addr;
    logic signed [W_W-1:0]    cfg_wdata;
    logic                     cfg_ready;
    logic                     cfg_err;

    logic                     in_valid;
    logic                     in_ready;
    logic [N_IN-1:0]          x;

    logic                     out_valid;
    logic                     out_ready;
    logic                     predict;
    logic signed [ACC_W-1:0]  out_sum;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, x, out_ready,
        input  cfg_ready, cfg_err, in_ready, out_valid, predict, out_sum
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, x, out_ready,
        output cfg_ready, cfg_err, in_ready, out_valid, predict, out_sum
    );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Sequential 20-input perceptron: weight/bias register file plus one
// multiply-accumulate per clock, with valid/ready handshakes on both sides.
module neuron_seq_ctrl #(
    parameter int N_IN   = 20,
    parameter int W_W    = 8,
    parameter int ACC_W  = 13,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    neuron_seq_ctrl_if.slave   bus
);
    localparam int                IDX_W     = $clog2(N_IN);
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(N_IN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state, state_nxt;
    logic signed [W_W-1:0]    w_mem [N_IN+1];
    logic [N_IN-1:0]          x_reg;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  sum_r;
    logic                     predict_r;
    logic                     cfg_err_r;
    logic                     in_ready_c;
    logic                     cfg_ready_c;
    logic                     out_valid_c;
    logic                     accept;
    logic                     cfg_hit;
    logic                     cfg_drop;

    function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [W_W-1:0] v);
        return {{(ACC_W-W_W){v[W_W-1]}}, v};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        cfg_ready_c = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c  = 1'b1;
                cfg_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept   = bus.in_valid & in_ready_c;
        cfg_hit  = bus.cfg_we & cfg_ready_c & (bus.cfg_addr <= BIAS_ADDR);
        cfg_drop = bus.cfg_we & ~cfg_hit;
        acc_nxt  = acc + (x_reg[idx] ? sext_w(w_mem[idx]) : '0);
    end

    // Weight writes use non-blocking updates, so a vector accepted on the
    // same edge as a bias write still starts from the old bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= N_IN; i++) w_mem[i] <= '0;
            x_reg     <= '0;
            idx       <= '0;
            acc       <= '0;
            sum_r     <= '0;
            predict_r <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_drop;
            if (cfg_hit) w_mem[bus.cfg_addr] <= bus.cfg_wdata;
            if (accept) begin
                x_reg <= bus.x;
                acc   <= sext_w(w_mem[N_IN]);
                idx   <= '0;
            end else if (state == ACCUM) begin
                acc <= acc_nxt;
                idx <= idx + 1'b1;
                if (idx == LAST_IDX) begin
                    sum_r     <= acc_nxt;
                    predict_r <= (acc_nxt > 0);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.cfg_ready = cfg_ready_c;
    assign bus.cfg_err   = cfg_err_r;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = sum_r;
    assign bus.predict   = predict_r;
endmodule

// File: doc/neuron_seq_ctrl.md
Name: neuron_seq_ctrl

Overview:
- Sequential controller for the 20-input perceptron neuron.
- Owns the weight/bias register file, loaded over a config write port.
- Accepts one feature vector per valid/ready handshake and evaluates it with one time-multiplexed multiply-accumulate per clock.
- Returns the registered sign decision and the raw sum to the downstream consumer.

Parameters:
- N_IN, 20, number of binary inputs and weights.
- W_W, 8, weight and bias width, two's-complement signed.
- ACC_W, 13, accumulator width, signed. Must satisfy 2^(ACC_W-1) > (N_IN+1)*2^(W_W-1).
- ADDR_W, 5, config address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  ADDR_W  0..N_IN-1 selects a weight; N_IN selects the bias.
- cfg_wdata  in  W_W  signed weight/bias value.
- cfg_ready  out  1  high when a config write will be accepted.
- cfg_err  out  1  one-cycle pulse on a dropped config write.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  controller can accept a vector.
- x  in  N_IN  binary feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- predict  out  1  1 when the sum is strictly greater than 0.
- out_sum  out  ACC_W  signed sum: bias + Σ x[i]*w[i].

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - All weights and bias cleared to 0.
  - Accumulator, index, x_reg, predict, out_sum = 0.
  - out_valid=0, cfg_err=0.
  - Any in-flight evaluation is discarded with no output.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1, cfg_ready=1.
  - On in_valid&in_ready: latch x into x_reg, set acc=sign-extended bias, idx=0, go to ACCUM.
  - A config write in the same cycle as an accepted input is applied. The input captures the pre-write value of the written entry.
- ACCUM:
  - in_ready=0, cfg_ready=0.
  - Each cycle: acc += x_reg[idx] ? sext(w[idx]) : 0; idx++.
  - After the add at idx=N_IN-1: register predict=(acc_next>0) and out_sum=acc_next, assert out_valid, go to DONE.
- DONE:
  - out_valid=1; predict and out_sum held stable.
  - in_ready=0, cfg_ready=0.
  - On out_ready: clear out_valid, go to IDLE.
- Latency: out_valid rises exactly N_IN clock edges after the accepting edge. Minimum spacing between accepted vectors is N_IN+2 cycles when out_ready is tied high.
- Arithmetic and decision:
  - Products are signed W_W values, sign-extended to ACC_W. No saturation is needed given the ACC_W constraint.
  - Decision is a strict signed compare: sum=0 gives predict=0.
- Config writes:
  - A write lands on the clock edge where cfg_we&cfg_ready.
  - cfg_we while cfg_ready=0 is dropped; cfg_err pulses for one cycle.
  - cfg_addr > N_IN is dropped with a cfg_err pulse, even in IDLE.
  - Weights are never modified during ACCUM or DONE.
- in_valid while in_ready=0 is ignored. The source must hold in_valid and x until it sees in_ready.
- out_valid never drops without out_ready.
- Mid-operation reset returns to IDLE within the reset assertion, independent of clk.

Test Plan:
- Reset then load w = {+2,-2,-2,0,0,+2,-2,+2,-2,-2,+2,-2,+2,-2,-2,0,+4,+2,0,0} (index 0 first, i.e. 0x02, 0xFE, ...) and bias=0. Drive x=20'hFFFFF -> after 20 cycles out_sum=0, predict=0.
- Same weights, x with only bit16 set -> out_sum=4, predict=1. x with only bit1 set -> out_sum=-2, predict=0. Check out_valid rises exactly 20 edges after acceptance.
- All weights and bias 0x80, x=20'hFFFFF -> out_sum=-2688, predict=0. All weights and bias 0x7F -> out_sum=2667, predict=1. Confirms no overflow at ACC_W=13.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, predict and out_sum stable; in_ready=0. Pulse out_ready -> returns to IDLE; next vector is accepted the following cycle.
- Config during ACCUM and illegal address: cfg_we to addr 3 mid-evaluation, then cfg_we to addr 25 in IDLE -> cfg_err pulses each time, weights unchanged, results unaffected.
- Assert rst_n low at the 10th ACCUM cycle -> out_valid stays 0, state=IDLE, weights read back as 0. A following x=20'hFFFFF gives out_sum=0, predict=0.
